uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Frame-level controller for the UART receiver. Oversamples RX_IN and sequences
//  start/data/parity/stop bits. Computes expected parity and drives the external
//  parity checker (par_chk_en/par_bit/par_calc in, par_err back).
//  Deserializes data; emits P_DATA plus a one-cycle data_valid pulse for error-free frames.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame, LSB first
//  PRESCALE    8  CLK cycles per bit (even, >=6); sampling at mid-bit
// PORTS
//  CLK          in   1           receiver clock (oversampling clock)
//  RST          in   1           asynchronous, active-low reset
//  RX_IN        in   1           serial line, idle high, already synchronous to CLK
//  PAR_EN       in   1           1: frame carries a parity bit
//  PAR_TYP      in   1           0: even, 1: odd
//  par_err      in   1           from parity checker; meaningful only while par_chk_en=1
//  par_chk_en   out  1           checker enable, 1 cycle at end of parity bit
//  par_bit      out  1           received (majority-sampled) parity bit to checker
//  par_calc     out  1           expected parity computed from received data
//  P_DATA       out  DATA_WIDTH  last good frame's data; holds until next good frame
//  data_valid   out  1           1-cycle pulse, P_DATA updated same cycle
//  par_err_flag out  1           1-cycle pulse: parity error, frame dropped
//  stp_err_flag out  1           1-cycle pulse: stop bit sampled 0, frame dropped
//  busy         out  1           1 in any state except IDLE
// BEHAVIOUR
//  Reset (RST=0, async): state=IDLE, counters 0, every output 0 (P_DATA=0).
//  Timing: edge_cnt runs 0..PRESCALE-1 per bit, wraps to 0 and advances bit_cnt.
//   Bit value = majority of RX_IN at edge_cnt PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1;
//   decision made when edge_cnt==PRESCALE-1 (end of bit).
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE:   RX_IN==0 -> START, edge_cnt=0 next cycle; latch PAR_EN/PAR_TYP for the frame.
//   START:  end of bit: sampled 1 -> IDLE (glitch, no flag); sampled 0 -> DATA.
//   DATA:   shift sampled bit into shift reg LSB-first; after DATA_WIDTH bits ->
//           PARITY if latched PAR_EN else STOP.
//   PARITY: par_calc = ^data (even) / ~^data (odd), stable whole state; par_bit follows
//           sampler. par_chk_en=1 only at edge_cnt==PRESCALE-1; par_err captured
//           that cycle. par_err is ignored at all other times (checker reports 1 when disabled).
//   STOP:   end of bit: sampled 0 -> stp_err_flag; else if parity captured bad ->
//           par_err_flag; else P_DATA<=shift reg, data_valid=1. Always -> IDLE.
//  Stop error takes precedence over parity error; never both flags in one frame.
//  Latency: RX_IN low at cycle t -> flag/data_valid at t+1+NB*PRESCALE,
//   NB = DATA_WIDTH+2 (+1 with parity). Defaults with parity: t+89.
//  Back-to-back: one IDLE cycle between frames; RX_IN low in that cycle starts next frame.
//  PAR_EN/PAR_TYP changes mid-frame take effect next frame only.
//  Reset mid-frame: frame discarded, no flags, no data_valid.
//  Width rules: edge_cnt $clog2(PRESCALE) bits, bit_cnt $clog2(DATA_WIDTH+1) bits, no overflow.
// STRUCTURE
//  uart_rx_pkg: state encoding (IDLE/START/DATA/PARITY/STOP), PAR_EVEN/PAR_ODD constants,
//   sample-point offsets.
//  Sub-module uart_rx_sampler: edge counter + 3-sample majority, outputs sampled bit and
//   bit_end strobe. FSM, bit counter, shift reg, parity calc stay in uart_rx_ctrl.
// TESTING
//  1 Defaults, PAR_EN=1 even, frame 0xA5 parity 0 -> data_valid at t+89, P_DATA=0xA5, no flags.
//  2 PAR_EN=1 odd, 0x3C with parity bit 0 (wrong) -> par_err_flag pulse, no data_valid, P_DATA unchanged.
//  3 PAR_EN=0, 0x81 with stop bit 0 -> stp_err_flag at t+81, no data_valid.
//  4 RX_IN low 3 cycles then high (glitch) -> back to IDLE after 8 cycles, no outputs, busy drops.
//  5 Two back-to-back frames 0x55,0xAA, single-cycle-noise on one sample per bit -> both valid.
//  6 RST low mid-DATA, release, send 0x0F -> no pulse for aborted frame; 0x0F received cleanly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam logic ParEven = 1'b0;
  localparam logic ParOdd  = 1'b1;

  // Samples are taken at mid-bit and one clock either side of it.
  localparam int unsigned SampleSpan = 1;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three-point mid-bit majority sampling.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic rx,
  output logic sampled,
  output logic bit_end
);

  localparam int unsigned EW = $clog2(PRESCALE);
  localparam logic [EW-1:0] EdgeLast    = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] SampleEarly = EW'(PRESCALE / 2 - SampleSpan);
  localparam logic [EW-1:0] SampleMid   = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] SampleLate  = EW'(PRESCALE / 2 + SampleSpan);

  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]    smp_q, smp_d;

  always_comb begin
    edge_cnt_d = '0;
    smp_d      = smp_q;
    if (en) begin
      if (edge_cnt_q != EdgeLast) edge_cnt_d = edge_cnt_q + 1'b1;
      if (edge_cnt_q == SampleEarly) smp_d[0] = rx;
      if (edge_cnt_q == SampleMid)   smp_d[1] = rx;
      if (edge_cnt_q == SampleLate)  smp_d[2] = rx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
      smp_q      <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      smp_q      <= smp_d;
    end
  end

  assign bit_end = en && (edge_cnt_q == EdgeLast);
  assign sampled = majority3(smp_q);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start/data/parity/stop sequencing, deserializer and
// result reporting toward the external parity checker and the consumer.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  par_err,
  output logic                  par_chk_en,
  output logic                  par_bit,
  output logic                  par_calc,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err_flag,
  output logic                  stp_err_flag,
  output logic                  busy
);

  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BitLast = BW'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_bad_q, par_bad_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_flag_q, par_err_flag_d;
  logic                  stp_err_flag_q, stp_err_flag_d;
  logic                  sampled, bit_end;

  uart_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .clk    (CLK),
    .rst_n  (RST),
    .en     (state_q != StIdle),
    .rx     (RX_IN),
    .sampled(sampled),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    p_data_d       = p_data_q;
    par_en_d       = par_en_q;
    par_typ_d      = par_typ_q;
    par_bad_d      = par_bad_q;
    data_valid_d   = 1'b0;
    par_err_flag_d = 1'b0;
    stp_err_flag_d = 1'b0;
    par_chk_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!RX_IN) begin
          state_d   = StStart;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
        end
      end
      StStart: begin
        // A high majority means the falling edge was a glitch.
        if (bit_end) state_d = sampled ? StIdle : StData;
      end
      StData: begin
        if (bit_end) begin
          shift_d = {sampled, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        par_chk_en = bit_end;
        if (bit_end) begin
          par_bad_d = par_err;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          if (!sampled) begin
            stp_err_flag_d = 1'b1;
          end else if (par_bad_q) begin
            par_err_flag_d = 1'b1;
          end else begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      p_data_q       <= '0;
      par_en_q       <= 1'b0;
      par_typ_q      <= ParEven;
      par_bad_q      <= 1'b0;
      data_valid_q   <= 1'b0;
      par_err_flag_q <= 1'b0;
      stp_err_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      p_data_q       <= p_data_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      par_bad_q      <= par_bad_d;
      data_valid_q   <= data_valid_d;
      par_err_flag_q <= par_err_flag_d;
      stp_err_flag_q <= stp_err_flag_d;
    end
  end

  assign par_calc     = (state_q == StParity) && ((^shift_q) ^ (par_typ_q == ParOdd));
  assign par_bit      = (state_q == StParity) && sampled;
  assign P_DATA       = p_data_q;
  assign data_valid   = data_valid_q;
  assign par_err_flag = par_err_flag_q;
  assign stp_err_flag = stp_err_flag_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed vector table, corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_uart_rx_ctrl;

  localparam int P = 8;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         RX_IN = 1'b1;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic         par_err;
  logic         par_chk_en, par_bit, par_calc;
  logic [W-1:0] P_DATA;
  logic         data_valid, par_err_flag, stp_err_flag, busy;

  uart_rx_ctrl #(
    .DATA_WIDTH(W),
    .PRESCALE  (P)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .par_err     (par_err),
    .par_chk_en  (par_chk_en),
    .par_bit     (par_bit),
    .par_calc    (par_calc),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_err_flag(par_err_flag),
    .stp_err_flag(stp_err_flag),
    .busy        (busy)
  );

  // External parity checker: reports an error whenever it is disabled.
  assign par_err = par_chk_en ? (par_bit ^ par_calc) : 1'b1;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // kind encoding {stp, par, valid}
  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       ptyp;
    logic       pbit;
    logic       stopb;
    logic [2:0] exp_kind;
    logic [7:0] exp_pdata;
  } vec_t;

  ev_t  obs_q[$];
  ev_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   chk_en_cnt = 0;
  int   pen_frames = 0;
  logic [7:0] last_good;

  always @(negedge CLK) begin
    if (data_valid || par_err_flag || stp_err_flag)
      obs_q.push_back('{kind: {stp_err_flag, par_err_flag, data_valid}, data: P_DATA, cyc: cyc});
    if (par_chk_en) chk_en_cnt <= chk_en_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic flush(input string tag);
    int n;
    repeat (20) @(negedge CLK);
    check({tag, " event count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s ev%0d kind", tag, i), obs_q[i].kind, exp_q[i].kind);
      check($sformatf("%s ev%0d P_DATA", tag, i), obs_q[i].data, exp_q[i].data);
      check($sformatf("%s ev%0d cycle", tag, i), obs_q[i].cyc, exp_q[i].cyc);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Drives one frame starting on the next negedge; t0 is the cycle RX_IN first goes low.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic pbit, input logic stopb, input bit noise,
                            input bit chg, input int gap, output int t0, output int nb);
    logic bits [0:W+2];
    int   nz;
    nb = pen ? W + 3 : W + 2;
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[1+i] = d[i];
    if (pen) bits[W+1] = pbit;
    bits[nb-1] = stopb;
    if (pen) pen_frames++;
    @(negedge CLK);
    PAR_EN  = pen;
    PAR_TYP = ptyp;
    t0 = cyc;
    for (int b = 0; b < nb; b++) begin
      nz = noise ? int'($urandom_range(7, (b == 0) ? 1 : 0)) : -1;
      for (int k = 0; k < P; k++) begin
        if (b != 0 || k != 0) @(negedge CLK);
        RX_IN = (k == nz) ? ~bits[b] : bits[b];
        if (chg && b == 3 && k == 0) begin
          PAR_EN  = 1'($urandom);
          PAR_TYP = 1'($urandom);
        end
      end
    end
    repeat (gap) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  initial begin
    vec_t       vecs[8];
    ev_t        e;
    int         t0, nb;
    logic [7:0] d;
    logic       pen, ptyp, pbit, stopb, exp_par;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 8'hA5};
    vecs[2] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 8'hA5};
    vecs[3] = '{8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 8'h81};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 8'h3C};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 3'b100, 8'h3C};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 8'h3C};
    vecs[7] = '{8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 8'h7E};

    // Reset state
    repeat (2) @(negedge CLK);
    check("reset data_valid", data_valid, 0);
    check("reset par_err_flag", par_err_flag, 0);
    check("reset stp_err_flag", stp_err_flag, 0);
    check("reset busy", busy, 0);
    check("reset par_chk_en", par_chk_en, 0);
    check("reset par_bit", par_bit, 0);
    check("reset par_calc", par_calc, 0);
    check("reset P_DATA", P_DATA, 0);
    RST = 1'b1;
    repeat (4) @(negedge CLK);

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].data, vecs[v].pen, vecs[v].ptyp, vecs[v].pbit, vecs[v].stopb,
                 1'b0, 1'b0, 1, t0, nb);
      e = '{kind: vecs[v].exp_kind, data: vecs[v].exp_pdata, cyc: t0 + 1 + P * nb};
      exp_q.push_back(e);
      flush($sformatf("vec%0d", v));
    end

    // Start-bit glitch: three low cycles must not start a frame
    @(negedge CLK);
    RX_IN = 1'b0;
    t0 = cyc;
    repeat (2) @(negedge CLK);
    @(negedge CLK);
    RX_IN = 1'b1;
    repeat (5) @(negedge CLK);
    check("glitch busy at end of start bit", busy, 1);
    @(negedge CLK);
    check("glitch busy after start bit", busy, 0);
    check("glitch elapsed cycles", cyc - t0, 9);
    flush("glitch");

    // Back-to-back frames with single-cycle noise in every bit
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, t0, nb);
    exp_q.push_back('{kind: 3'b001, data: 8'h55, cyc: t0 + 1 + P * nb});
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, t0, nb);
    exp_q.push_back('{kind: 3'b001, data: 8'hAA, cyc: t0 + 1 + P * nb});
    flush("b2b");

    // Reset in the middle of the data bits
    @(negedge CLK);
    PAR_EN = 1'b0;
    RX_IN  = 1'b0;
    repeat (7) @(negedge CLK);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      RX_IN = (i % 16) >= 8;
    end
    check("busy before abort", busy, 1);
    @(negedge CLK);
    RST   = 1'b0;
    RX_IN = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort P_DATA", P_DATA, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    flush("abort");
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, t0, nb);
    exp_q.push_back('{kind: 3'b001, data: 8'h0F, cyc: t0 + 1 + P * nb});
    flush("after abort");

    // Randomized frames against the frame-level model
    last_good = 8'h0F;
    for (int f = 0; f < 40; f++) begin
      d     = 8'($urandom);
      pen   = 1'($urandom);
      ptyp  = 1'($urandom);
      pbit  = 1'($urandom);
      stopb = ($urandom_range(5, 0) != 0);
      send_frame(d, pen, ptyp, pbit, stopb, 1'b1, 1'($urandom), int'($urandom_range(3, 1)),
                 t0, nb);
      exp_par = (^d) ^ ptyp;
      if (!stopb) e.kind = 3'b100;
      else if (pen && (pbit != exp_par)) e.kind = 3'b010;
      else begin
        e.kind    = 3'b001;
        last_good = d;
      end
      e.data = last_good;
      e.cyc  = t0 + 1 + P * nb;
      exp_q.push_back(e);
    end
    flush("random");

    check("par_chk_en pulse count", chk_en_cnt, pen_frames);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
